// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - keypad countdown timer sequencing controller
//
// Shifts keypad digits (1..6) into an MM:SS BCD setpoint while idle, then
// counts it down to 00:00 at one step per TICK_DIV clocks.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_key_valid  one-cycle strobe qualifying i_bcd_data
//   i_bcd_data   digit code; only 1..6 are accepted
//   i_start      start / pause / resume toggle (also leaves DONE)
//   i_clear      abort to IDLE with time cleared
//   o_time       BCD {M10,M1,S10,S1}
//   o_state      IDLE=0, RUN=1, PAUSE=2, DONE=3
//   o_tick       one-cycle pulse on each decrement
//   o_done       high while in DONE
//   o_err        one-cycle pulse when a start is rejected
module timer_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_key_valid,
  input  logic [4:0]  i_bcd_data,
  input  logic        i_start,
  input  logic        i_clear,
  output logic [15:0] o_time,
  output logic [1:0]  o_state,
  output logic        o_tick,
  output logic        o_done,
  output logic        o_err
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_d, err_d;
  logic          tick_hit;
  logic          digit_ok;
  logic [15:0]   time_dec;

  // One-second BCD decrement. Each lane borrows from the next only when it
  // is zero; seconds tens wrap to 5, all other lanes wrap to 9.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] s1, s10, m1, m10;
    s1  = t[3:0];
    s10 = t[7:4];
    m1  = t[11:8];
    m10 = t[15:12];
    if (s1 != 4'd0) begin
      s1 = s1 - 4'd1;
    end else begin
      s1 = 4'd9;
      if (s10 != 4'd0) begin
        s10 = s10 - 4'd1;
      end else begin
        s10 = 4'd5;
        if (m1 != 4'd0) begin
          m1 = m1 - 4'd1;
        end else begin
          m1  = 4'd9;
          m10 = m10 - 4'd1;
        end
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  assign tick_hit = (presc_q == PRESC_LAST);
  assign digit_ok = (i_bcd_data >= 5'd1) && (i_bcd_data <= 5'd6);
  assign time_dec = bcd_dec(time_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      time_q  <= 16'h0000;
      presc_q <= '0;
      o_tick  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      presc_q <= presc_d;
      o_tick  <= tick_d;
      o_err   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    err_d   = 1'b0;
    if (i_clear) begin
      state_d = IDLE;
      time_d  = 16'h0000;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            if (time_q == 16'h0000) begin
              state_d = IDLE;
            end else if (time_q[7:4] > 4'd5) begin
              err_d = 1'b1;
            end else begin
              state_d = RUN;
              presc_d = '0;
            end
          end else if (i_key_valid && digit_ok) begin
            time_d = {time_q[11:0], i_bcd_data[3:0]};
          end
        end
        RUN: begin
          if (tick_hit) begin
            presc_d = '0;
            time_d  = time_dec;
            tick_d  = 1'b1;
            // Reaching zero takes precedence over a coincident pause.
            if (time_dec == 16'h0000) begin
              state_d = DONE;
            end else if (i_start) begin
              state_d = PAUSE;
            end
          end else begin
            presc_d = presc_q + 1'b1;
            if (i_start) begin
              state_d = PAUSE;
            end
          end
        end
        PAUSE: begin
          if (i_start) begin
            state_d = RUN;
          end
        end
        DONE: begin
          time_d = 16'h0000;
          if (i_start) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign o_time  = time_q;
  assign o_state = state_q;
  assign o_done  = (state_q == DONE);

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - directed self-checking bench for timer_ctrl
module tb_timer_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_key_valid = 1'b0;
  logic [4:0]  i_bcd_data = 5'd0;
  logic        i_start = 1'b0;
  logic        i_clear = 1'b0;
  logic [15:0] o_time;
  logic [1:0]  o_state;
  logic        o_tick;
  logic        o_done;
  logic        o_err;

  int compared = 0;
  int mismatched = 0;

  timer_ctrl #(.TICK_DIV(4)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_key_valid (i_key_valid),
    .i_bcd_data  (i_bcd_data),
    .i_start     (i_start),
    .i_clear     (i_clear),
    .o_time      (o_time),
    .o_state     (o_state),
    .o_tick      (o_tick),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic key(input logic [4:0] d);
    i_key_valid = 1'b1;
    i_bcd_data  = d;
    step(1);
    i_key_valid = 1'b0;
    i_bcd_data  = 5'd0;
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
  endtask

  task automatic clear_pulse();
    i_clear = 1'b1;
    step(1);
    i_clear = 1'b0;
  endtask

  initial begin
    // Reset state
    step(2);
    check("rst_time",  o_time, 16'h0000);
    check("rst_state", {14'd0, o_state}, 16'd0);
    check("rst_tick",  {15'd0, o_tick}, 16'd0);
    check("rst_done",  {15'd0, o_done}, 16'd0);
    check("rst_err",   {15'd0, o_err}, 16'd0);
    i_rst = 1'b0;
    step(1);

    // Digit entry, invalid codes ignored, oldest digit dropped
    key(5'd1);
    check("entry_1", o_time, 16'h0001);
    key(5'd2);
    key(5'd3);
    key(5'd4);
    check("entry_1234", o_time, 16'h1234);
    key(5'h0F);
    key(5'd7);
    key(5'd0);
    key(5'h1F);
    check("entry_invalid", o_time, 16'h1234);
    key(5'd5);
    check("entry_shift", o_time, 16'h2345);
    clear_pulse();
    check("clear_time", o_time, 16'h0000);

    // Borrow chain from 01:11
    key(5'd1);
    key(5'd1);
    key(5'd1);
    check("chain_entry", o_time, 16'h0111);
    start_pulse();
    check("chain_run", {14'd0, o_state}, 16'd1);
    step(3);
    check("chain_notick", {15'd0, o_tick}, 16'd0);
    check("chain_hold", o_time, 16'h0111);
    step(1);
    check("chain_t4", o_time, 16'h0110);
    check("chain_tick4", {15'd0, o_tick}, 16'd1);
    step(1);
    check("chain_tick_lo", {15'd0, o_tick}, 16'd0);
    step(3);
    check("chain_t8", o_time, 16'h0109);
    step(36);
    check("chain_t44", o_time, 16'h0100);
    step(4);
    check("chain_t48", o_time, 16'h0059);
    step(4);
    check("chain_t52", o_time, 16'h0058);
    // Clear beats a simultaneous start in RUN
    i_clear = 1'b1;
    i_start = 1'b1;
    step(1);
    i_clear = 1'b0;
    i_start = 1'b0;
    check("clr_start_state", {14'd0, o_state}, 16'd0);
    check("clr_start_time", o_time, 16'h0000);

    // Run to done from 00:02
    key(5'd2);
    start_pulse();
    step(4);
    check("done_t4", o_time, 16'h0001);
    step(3);
    check("done_pre_tick", {15'd0, o_tick}, 16'd0);
    step(1);
    check("done_time", o_time, 16'h0000);
    check("done_state", {14'd0, o_state}, 16'd3);
    check("done_flag", {15'd0, o_done}, 16'd1);
    check("done_tick", {15'd0, o_tick}, 16'd1);
    step(3);
    check("done_hold_state", {14'd0, o_state}, 16'd3);
    check("done_hold_tick", {15'd0, o_tick}, 16'd0);
    start_pulse();
    check("done_exit_state", {14'd0, o_state}, 16'd0);
    check("done_exit_flag", {15'd0, o_done}, 16'd0);

    // Pause and resume of a partial period
    key(5'd3);
    start_pulse();
    step(1);
    start_pulse();
    check("pause_state", {14'd0, o_state}, 16'd2);
    step(10);
    check("pause_time", o_time, 16'h0003);
    check("pause_state_hold", {14'd0, o_state}, 16'd2);
    start_pulse();
    check("resume_state", {14'd0, o_state}, 16'd1);
    step(1);
    check("resume_notick", {15'd0, o_tick}, 16'd0);
    step(1);
    check("resume_tick", {15'd0, o_tick}, 16'd1);
    check("resume_time", o_time, 16'h0002);

    // Asynchronous reset mid-run
    step(1);
    i_rst = 1'b1;
    #1;
    check("arst_time", o_time, 16'h0000);
    check("arst_state", {14'd0, o_state}, 16'd0);
    check("arst_tick", {15'd0, o_tick}, 16'd0);
    step(2);
    i_rst = 1'b0;
    step(1);
    key(5'd4);
    check("arst_entry", o_time, 16'h0004);
    clear_pulse();

    // Rejected start on invalid seconds, ignored start on 00:00
    key(5'd6);
    key(5'd1);
    check("rej_entry", o_time, 16'h0061);
    start_pulse();
    check("rej_err", {15'd0, o_err}, 16'd1);
    check("rej_state", {14'd0, o_state}, 16'd0);
    check("rej_time", o_time, 16'h0061);
    step(1);
    check("rej_err_lo", {15'd0, o_err}, 16'd0);
    clear_pulse();
    start_pulse();
    check("zero_state", {14'd0, o_state}, 16'd0);
    check("zero_err", {15'd0, o_err}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
